uart_rx: RTL and testbench

- Serial receiver; the downstream counterpart of the UART transmitter.
- Recovers frames from the asynchronous rx line using the same configuration set: enable, divider, 5–8 data bits, optional parity, 1 or 2 stop bits.
- Delivers each received character on a valid/ready stream through a one-entry holding register, with per-character parity and framing error flags.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_baud.sv | 42 ++++
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e  - frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   DATA_BITS_OFS - cfg_bits value 0 selects this many data bits
//   DIV_MIN       - smallest usable bit period in clk cycles
//   eff_div()     - clamps a configured divider to DIV_MIN
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned DATA_BITS_OFS = 5;
    localparam logic [11:0] DIV_MIN       = 12'd4;

    function automatic logic [11:0] eff_div(input logic [11:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/uart_rx_baud.sv
// uart_rx_baud: bit-period counter for the UART receiver.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   restart_i     force the count back to 0 (takes priority over en_i)
//   en_i          count enable
//   div_i         configured bit period; values below DIV_MIN act as DIV_MIN
//   half_o        strobe at count P/2-1 (mid start bit after an edge restart)
//   full_o        strobe at count P-1 (mid bit after a restart at mid start bit)
module uart_rx_baud
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        restart_i,
    input  logic        en_i,
    input  logic [11:0] div_i,
    output logic        half_o,
    output logic        full_o
);

    logic [11:0] cnt;
    logic [11:0] period;
    logic [11:0] last_cnt;
    logic [11:0] half_cnt;

    assign period   = eff_div(div_i);
    assign last_cnt = period - 12'd1;
    assign half_cnt = (period >> 1) - 12'd1;

    // >= on the wrap keeps the counter bounded if the divider shrinks mid-count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (restart_i)
            cnt <= '0;
        else if (en_i)
            cnt <= (cnt >= last_cnt) ? 12'd0 : cnt + 12'd1;
    end

    assign half_o = en_i && (cnt == half_cnt);
    assign full_o = en_i && (cnt == last_cnt);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with a one-entry valid/ready output.
//   clk_i, rst_i       clock, asynchronous active-high reset
//   cfg_en_i           receiver enable; low forces IDLE and empties the holding register
//   cfg_div_i          bit period in clk cycles (min 4)
//   cfg_bits_i         data bits 5..8 (0..3)
//   cfg_parity_en_i    expect an even-parity bit after the data
//   cfg_stop_bits_i    1 = two stop bits
//   rx_i               serial line, idle high
//   rx_busy_o          frame in progress
//   rx_data_o/perr/ferr held character and its error flags
//   rx_vld_o, rx_rdy_i holding register handshake
//   rx_ovr_o           one-cycle pulse when a completed frame is dropped
// Optional build macro UART_RX_MAJORITY_EN: each sample point takes a 2-of-3
// vote over the strobe cycle and its neighbours, decided one cycle later.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_en_i,
    input  logic [11:0] cfg_div_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_parity_en_i,
    input  logic        cfg_stop_bits_i,
    input  logic        rx_i,
    output logic        rx_busy_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_perr_o,
    output logic        rx_ferr_o,
    output logic        rx_vld_o,
    input  logic        rx_rdy_i,
    output logic        rx_ovr_o
);

    // ---------------- input synchroniser + edge detect ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   start_edge;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_prev <= rx_s;
        end
    end

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = rx_prev && !rx_s;

    // ---------------- baud timing ----------------
    uart_state_e state;
    logic        half;
    logic        full;
    logic        strobe;
    logic        smp_evt;
    logic        smp_bit;
    logic        restart;

    assign strobe  = (state == START) ? half : (state != IDLE) ? full : 1'b0;
    assign restart = ((state == IDLE) && start_edge) ||
                     ((state == START) && smp_evt && !smp_bit);

    uart_rx_baud u_baud (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (restart),
        .en_i      ((state != IDLE) && cfg_en_i),
        .div_i     (cfg_div_i),
        .half_o    (half),
        .full_o    (full)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist holds the line at strobe-1 and strobe while rx_s is strobe+1,
    // so the vote lands the cycle after the strobe.
    logic [1:0] hist;
    logic       strobe_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist     <= 2'b11;
            strobe_d <= 1'b0;
        end else begin
            hist     <= {hist[0], rx_s};
            strobe_d <= strobe && cfg_en_i;
        end
    end

    assign smp_evt = strobe_d;
    assign smp_bit = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign smp_evt = strobe;
    assign smp_bit = rx_s;
`endif

    // ---------------- frame state machine ----------------
    logic [2:0] bit_cnt;
    logic [2:0] last_bit;
    logic       stop_idx;
    logic [7:0] shreg;
    logic       perr_q;
    logic       ferr_q;
    logic       done_q;

    assign last_bit = {1'b0, cfg_bits_i} + 3'(DATA_BITS_OFS - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rx_busy_o <= 1'b0;
            bit_cnt   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (!cfg_en_i) begin
            state     <= IDLE;
            rx_busy_o <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    // Clearing here may coincide with delivery of the previous
                    // frame; the holding register samples the old values.
                    state     <= START;
                    rx_busy_o <= 1'b1;
                    bit_cnt   <= '0;
                    stop_idx  <= 1'b0;
                    shreg     <= '0;
                    perr_q    <= 1'b0;
                    ferr_q    <= 1'b0;
                end
                START: if (smp_evt) begin
                    if (!smp_bit) begin
                        state <= DATA;
                    end else begin
                        state     <= IDLE;
                        rx_busy_o <= 1'b0;
                    end
                end
                DATA: if (smp_evt) begin
                    shreg[bit_cnt] <= smp_bit;
                    if (bit_cnt == last_bit)
                        state <= cfg_parity_en_i ? PARITY : STOP;
                    else
                        bit_cnt <= bit_cnt + 3'd1;
                end
                PARITY: if (smp_evt) begin
                    perr_q <= smp_bit ^ (^shreg);
                    state  <= STOP;
                end
                STOP: if (smp_evt) begin
                    if (!smp_bit)
                        ferr_q <= 1'b1;
                    if (cfg_stop_bits_i && !stop_idx) begin
                        stop_idx <= 1'b1;
                    end else begin
                        // Re-arm mid-stop-bit so back-to-back frames are caught.
                        state     <= IDLE;
                        rx_busy_o <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rx_busy_o <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- holding register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_vld_o  <= 1'b0;
            rx_data_o <= '0;
            rx_perr_o <= 1'b0;
            rx_ferr_o <= 1'b0;
            rx_ovr_o  <= 1'b0;
        end else if (!cfg_en_i) begin
            rx_vld_o  <= 1'b0;
            rx_data_o <= '0;
            rx_perr_o <= 1'b0;
            rx_ferr_o <= 1'b0;
            rx_ovr_o  <= 1'b0;
        end else begin
            rx_ovr_o <= 1'b0;
            if (done_q) begin
                if (!rx_vld_o || rx_rdy_i) begin
                    rx_vld_o  <= 1'b1;
                    rx_data_o <= shreg;
                    rx_perr_o <= perr_q;
                    rx_ferr_o <= ferr_q;
                end else begin
                    rx_ovr_o <= 1'b1;
                end
            end else if (rx_vld_o && rx_rdy_i) begin
                rx_vld_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are built bit by bit
// from the frame rules; expected characters go into a queue that a monitor
// pops on every accepted handshake.
module tb_uart_rx;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_en_i = 1'b0;
    logic [11:0] cfg_div_i = 12'd16;
    logic [1:0]  cfg_bits_i = 2'd3;
    logic        cfg_parity_en_i = 1'b0;
    logic        cfg_stop_bits_i = 1'b0;
    logic        rx_i = 1'b1;
    logic        rx_rdy_i = 1'b1;
    logic        rx_busy_o;
    logic [7:0]  rx_data_o;
    logic        rx_perr_o;
    logic        rx_ferr_o;
    logic        rx_vld_o;
    logic        rx_ovr_o;

    always #5 clk_i = ~clk_i;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_div_i       (cfg_div_i),
        .cfg_bits_i      (cfg_bits_i),
        .cfg_parity_en_i (cfg_parity_en_i),
        .cfg_stop_bits_i (cfg_stop_bits_i),
        .rx_i            (rx_i),
        .rx_busy_o       (rx_busy_o),
        .rx_data_o       (rx_data_o),
        .rx_perr_o       (rx_perr_o),
        .rx_ferr_o       (rx_ferr_o),
        .rx_vld_o        (rx_vld_o),
        .rx_rdy_i        (rx_rdy_i),
        .rx_ovr_o        (rx_ovr_o)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } char_t;

    char_t       exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int          ovr_cnt = 0;
    int unsigned vld_rise_cyc = 0;
    logic        vld_prev = 1'b0;
    logic        hold_pend = 1'b0;
    logic [9:0]  hold_val = '0;
    bit          rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: handshakes, overrun pulses, hold stability.
    always @(negedge clk_i) begin
        char_t e;
        if (rx_ovr_o) ovr_cnt++;
        if (rx_vld_o && !vld_prev) vld_rise_cyc = cyc;
        vld_prev = rx_vld_o;
        if (hold_pend && !rst_i && cfg_en_i)
            chk("hold_stable", {rx_data_o, rx_perr_o, rx_ferr_o}, hold_val);
        hold_pend = rx_vld_o && !rx_rdy_i;
        hold_val  = {rx_data_o, rx_perr_o, rx_ferr_o};
        if (rx_vld_o && rx_rdy_i) begin
            chk("char_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("char", {rx_data_o, rx_perr_o, rx_ferr_o}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_rdy) rx_rdy_i = 1'($urandom_range(0, 1));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one frame; spike_edge inverts the line for one clock (0 = none).
    task automatic send(input logic [7:0] d, input int nb, input bit par_en,
                        input bit two_stop, input bit par_flip, input bit stop_bad,
                        input int div, input int spike_edge,
                        input logic [7:0] exp_xor, input bit push);
        bit         bits[$];
        logic [7:0] mask;
        logic [7:0] dm;
        int         p;
        mask = 8'((1 << nb) - 1);
        dm   = d & mask;
        p    = (div < 4) ? 4 : div;
        cfg_div_i       = 12'(div);
        cfg_bits_i      = 2'(nb - 5);
        cfg_parity_en_i = par_en;
        cfg_stop_bits_i = two_stop;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
        if (par_en) bits.push_back((^dm) ^ par_flip);
        bits.push_back(!stop_bad);
        if (two_stop) bits.push_back(1'b1);
        if (push) exp_q.push_back('{dm ^ exp_xor, par_en && par_flip, stop_bad});
        for (int c = 0; c < bits.size() * p; c++) begin
            rx_i = bits[c / p] ^ (c + 1 == spike_edge);
            tick();
        end
        rx_i = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) tick();
        ticks(2);
        chk({"drain_", tag}, exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          base;
        int unsigned start_cyc;
        bit          saw_busy;
        logic [7:0]  d;
        int          nb;
        int          div;
        int          p;

        // Reset state
        ticks(3);
        chk("rst_outputs", {rx_busy_o, rx_vld_o, rx_perr_o, rx_ferr_o, rx_ovr_o, rx_data_o}, 0);
        rst_i = 1'b0;
        cfg_en_i = 1'b1;
        ticks(4);
        chk("idle_after_rst", {rx_busy_o, rx_vld_o}, 0);

        // Basic 8N1 frame and delivery latency (~9.5 bit periods)
        start_cyc = cyc;
        send(8'hA5, 8, 0, 0, 0, 0, 16, 0, 8'h00, 1);
        wait_drain("basic");
        chk("basic_latency", 32'((vld_rise_cyc - start_cyc) >= 154 &&
                                 (vld_rise_cyc - start_cyc) <= 160), 1);

        // 5 bits, parity, 2 stop bits: good then bad parity
        send(8'h13, 5, 1, 1, 0, 0, 16, 0, 8'h00, 1);
        send(8'h13, 5, 1, 1, 1, 0, 16, 0, 8'h00, 1);
        wait_drain("parity");

        // Back-to-back stream, no overrun
        base = ovr_cnt;
        send(8'h00, 8, 0, 0, 0, 0, 16, 0, 8'h00, 1);
        send(8'hFF, 8, 0, 0, 0, 0, 16, 0, 8'h00, 1);
        send(8'h55, 8, 0, 0, 0, 0, 16, 0, 8'h00, 1);
        wait_drain("b2b");
        chk("b2b_no_ovr", ovr_cnt - base, 0);

        // Overrun: consumer stalled over two frames
        base = ovr_cnt;
        rx_rdy_i = 1'b0;
        send(8'h3C, 8, 0, 0, 0, 0, 16, 0, 8'h00, 1);
        send(8'hC3, 8, 0, 0, 0, 0, 16, 0, 8'h00, 0);
        ticks(32);
        chk("ovr_vld", rx_vld_o, 1);
        chk("ovr_data_kept", rx_data_o, 8'h3C);
        chk("ovr_pulses", ovr_cnt - base, 1);
        rx_rdy_i = 1'b1;
        wait_drain("ovr");

        // Framing error: stop bit low, data still delivered
        send(8'h5A, 8, 0, 0, 0, 1, 16, 0, 8'h00, 1);
        ticks(4);
        wait_drain("ferr");

        // Break: continuous low yields exactly one frame with ferr
        exp_q.push_back('{8'h00, 1'b0, 1'b1});
        rx_i = 1'b0;
        ticks(20 * 16);
        chk("break_idle", rx_busy_o, 0);
        rx_i = 1'b1;
        wait_drain("break");
        ticks(64);
        chk("break_single", rx_vld_o, 0);

        // Glitch of 0.3 bit periods: false start
        saw_busy = 1'b0;
        rx_i = 1'b0;
        ticks(5);
        rx_i = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tick();
            saw_busy |= rx_busy_o;
        end
        chk("glitch_saw_busy", saw_busy, 1);
        chk("glitch_idle", {rx_busy_o, rx_vld_o}, 0);

        // Enable dropped mid-DATA
        rx_i = 1'b0;
        ticks(3 * 16);
        chk("abort_busy_before", rx_busy_o, 1);
        cfg_en_i = 1'b0;
        tick();
        chk("abort_busy_after", rx_busy_o, 0);
        rx_i = 1'b1;
        ticks(32);
        cfg_en_i = 1'b1;
        ticks(12 * 16);
        chk("abort_no_vld", rx_vld_o, 0);

        // Reset mid-frame with a held character
        rx_rdy_i = 1'b0;
        send(8'h81, 8, 0, 0, 0, 0, 16, 0, 8'h00, 0);
        ticks(16);
        chk("pre_rst_held", rx_vld_o, 1);
        rx_i = 1'b0;
        ticks(3 * 16);
        rst_i = 1'b1;
        #1;
        chk("rst_midframe", {rx_busy_o, rx_vld_o, rx_perr_o, rx_ferr_o, rx_ovr_o, rx_data_o}, 0);
        rx_i = 1'b1;
        ticks(4);
        rst_i = 1'b0;
        rx_rdy_i = 1'b1;
        ticks(8);

        // One-cycle spike at the middle of data bit 3
`ifdef UART_RX_MAJORITY_EN
        send(8'h00, 8, 0, 0, 0, 0, 16, 7 + 3 + 16 * 4, 8'h00, 1);
`else
        send(8'h00, 8, 0, 0, 0, 0, 16, 7 + 2 + 16 * 4, 8'h08, 1);
`endif
        wait_drain("spike");

        // Randomized frames with random consumer stalls
        base = ovr_cnt;
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            d   = 8'($urandom);
            nb  = $urandom_range(5, 8);
            div = $urandom_range(0, 24);
            p   = (div < 4) ? 4 : div;
            send(d, nb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 div, 0, 8'h00, 1);
            ticks($urandom_range(2, 2 * p));
        end
        wait_drain("random");
        rand_rdy = 1'b0;
        rx_rdy_i = 1'b1;
        chk("random_no_ovr", ovr_cnt - base, 0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
